sram_mem_stage_ctrl: RTL and testbench

- Parametrised data-memory controller for the MEM stage of the ARM pipeline.
- Replaces the single-cycle data memory with a multi-cycle external SRAM access. Each DATA_W-bit word is split into BEATS = DATA_W/SRAM_DW narrow SRAM transfers, with WAIT_CYCLES clock cycles per transfer.
- Drives a `ready` signal. Top level uses ~ready as the pipeline freeze, gating IF, ID/EX and EX/MEM.

---
 rtl/sram_mem_stage_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_mem_stage_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sram_mem_stage_ctrl.sv
// rtl/sram_mem_stage_ctrl.sv - MEM-stage data memory controller over a narrow multi-cycle SRAM
//
// Purpose: each DATA_W-bit load/store is serialised into BEATS = DATA_W/SRAM_DW
// SRAM transfers of WAIT_CYCLES clocks each. ready is the pipeline advance
// signal: high when no request is pending or when the access has just completed.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   wr_en      in   store request (wins over rd_en)
//   rd_en      in   load request
//   addr       in   32-bit byte address
//   wdata      in   DATA_W store data
//   rdata      out  DATA_W load data, held until the next read capture
//   ready      out  operation complete or no request pending
//   sram_addr  out  SRAM beat address
//   sram_wdata out  SRAM write data
//   sram_rdata in   SRAM read data
//   sram_we_n  out  SRAM write enable, active low
module sram_mem_stage_ctrl #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               sram_we_n
);

  localparam int BEATS   = DATA_W / SRAM_DW;
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic               wr_q, wr_d;
  logic [SRAM_AW-1:0] base_q, base_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               last_beat;
  logic               last_wait;
  logic [SRAM_AW-1:0] base_calc;

  // First SRAM beat of the addressed word; out-of-range addresses wrap silently.
  assign base_calc = SRAM_AW'((addr - 32'(BASE_ADDR)) >> BYTE_SH) * SRAM_AW'(BEATS);

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign last_wait = (wait_q == WW'(WAIT_CYCLES - 1));

  // DONE releases the pipeline for exactly one cycle; a still-asserted request
  // in the following IDLE cycle belongs to the next instruction.
  assign ready = ~(rd_en | wr_en) | (state_q == DONE);
  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    wr_d       = wr_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;

    case (state_q)
      IDLE: begin
        if (rd_en | wr_en) begin
          wr_d    = wr_en;
          base_d  = base_calc;
          wdata_d = wdata;
          beat_d  = '0;
          wait_d  = '0;
          state_d = BEAT;
        end
      end

      BEAT: begin
        sram_addr = base_q + SRAM_AW'(beat_q);
        sram_we_n = ~wr_q;
        for (int i = 0; i < BEATS; i++) begin
          if (beat_q == BW'(i)) begin
            if (wr_q) begin
              sram_wdata = wdata_q[i*SRAM_DW +: SRAM_DW];
            end else if (last_wait) begin
              // Sample on the final wait cycle so slow SRAM data has settled.
              rdata_d[i*SRAM_DW +: SRAM_DW] = sram_rdata;
            end
          end
        end
        if (last_wait) begin
          wait_d = '0;
          if (last_beat) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_mem_stage_ctrl.sv
// tb/tb_sram_mem_stage_ctrl.sv - scoreboard bench for sram_mem_stage_ctrl
module tb_sram_mem_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: WAIT_CYCLES=1
  logic        rst1, wr1, rd1, we1_n, rdy1;
  logic [31:0] addr1, wd1, rdat1;
  logic [17:0] sa1;
  logic [15:0] sw1, sr1;
  logic [15:0] mem1 [64];

  // Instance 3: WAIT_CYCLES=3
  logic        rst3, wr3, rd3, we3_n, rdy3;
  logic [31:0] addr3, wd3, rdat3;
  logic [17:0] sa3;
  logic [15:0] sw3, sr3;
  logic [15:0] mem3 [64];

  sram_mem_stage_ctrl #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst1), .wr_en(wr1), .rd_en(rd1), .addr(addr1), .wdata(wd1),
    .rdata(rdat1), .ready(rdy1), .sram_addr(sa1), .sram_wdata(sw1),
    .sram_rdata(sr1), .sram_we_n(we1_n)
  );

  sram_mem_stage_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .wr_en(wr3), .rd_en(rd3), .addr(addr3), .wdata(wd3),
    .rdata(rdat3), .ready(rdy3), .sram_addr(sa3), .sram_wdata(sw3),
    .sram_rdata(sr3), .sram_we_n(we3_n)
  );

  // Behavioural SRAMs: asynchronous read, write on clock edge.
  assign sr1 = mem1[sa1[5:0]];
  assign sr3 = mem3[sa3[5:0]];
  always @(posedge clk) if (!we1_n) mem1[sa1[5:0]] <= sw1;
  always @(posedge clk) if (!we3_n) mem3[sa3[5:0]] <= sw3;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // mask bits: 0 ready, 1 we_n, 2 sram_addr, 3 sram_wdata, 4 rdata
  typedef struct {
    string       tag;
    bit          i3;
    logic [4:0]  m;
    logic        rdy;
    logic        wen;
    logic [17:0] sa;
    logic [15:0] sw;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.m[0]) check({e.tag, ".ready"}, 32'(e.i3 ? rdy3  : rdy1),  32'(e.rdy));
      if (e.m[1]) check({e.tag, ".we_n"},  32'(e.i3 ? we3_n : we1_n), 32'(e.wen));
      if (e.m[2]) check({e.tag, ".saddr"}, 32'(e.i3 ? sa3   : sa1),   32'(e.sa));
      if (e.m[3]) check({e.tag, ".swdat"}, 32'(e.i3 ? sw3   : sw1),   32'(e.sw));
      if (e.m[4]) check({e.tag, ".rdata"}, e.i3 ? rdat3 : rdat1, e.rd);
    end
  end

  // One cycle: drive inputs just after the rising edge, queue what the DUT must show.
  task automatic step(input bit i3, input bit rs, input bit r, input bit w,
                      input logic [31:0] a, input logic [31:0] d, input string tag,
                      input logic [4:0] m, input logic rdy, input logic wen,
                      input logic [17:0] sa, input logic [15:0] sw, input logic [31:0] rd);
    exp_t x;
    @(posedge clk);
    #1;
    rst1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    rst3 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
    if (i3) begin rst3 = rs; rd3 = r; wr3 = w; addr3 = a; wd3 = d; end
    else    begin rst1 = rs; rd1 = r; wr1 = w; addr1 = a; wd1 = d; end
    x.tag = tag; x.i3 = i3; x.m = m; x.rdy = rdy; x.wen = wen;
    x.sa = sa; x.sw = sw; x.rd = rd;
    sb.push_back(x);
  endtask

  // Full write access on instance 1 (WAIT=1, two beats), request held through DONE.
  task automatic wr_access(input string tg, input logic [31:0] a, input logic [31:0] d,
                           input bit also_rd, input logic [31:0] rd_hold);
    logic [17:0] b;
    b = 18'((a - 32'd1024) >> 2) * 18'd2;
    step(0, 0, also_rd, 1, a, d, {tg, "_n0"}, 5'b00011, 0, 1, 0, 0, 0);
    step(0, 0, also_rd, 1, a, d, {tg, "_b0"}, 5'b01111, 0, 0, b,      d[15:0], 0);
    step(0, 0, also_rd, 1, a, d, {tg, "_b1"}, 5'b01111, 0, 0, b + 1,  d[31:16], 0);
    step(0, 0, also_rd, 1, a, d, {tg, "_dn"}, 5'b10011, 1, 1, 0, 0, rd_hold);
  endtask

  task automatic rd_access(input string tg, input logic [31:0] a, input logic [31:0] exp);
    logic [17:0] b;
    b = 18'((a - 32'd1024) >> 2) * 18'd2;
    step(0, 0, 1, 0, a, 0, {tg, "_n0"}, 5'b00011, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, a, 0, {tg, "_b0"}, 5'b00111, 0, 1, b, 0, 0);
    step(0, 0, 1, 0, a, 0, {tg, "_b1"}, 5'b00111, 0, 1, b + 1, 0, 0);
    step(0, 0, 1, 0, a, 0, {tg, "_dn"}, 5'b10011, 1, 1, 0, 0, exp);
  endtask

  task automatic idle(input bit i3, input string tg);
    step(i3, 0, 0, 0, 0, 0, tg, 5'b00011, 1, 1, 0, 0, 0);
  endtask

  initial begin
    rst1 = 1'b1; rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
    rst3 = 1'b1; rd3 = 0; wr3 = 0; addr3 = 0; wd3 = 0;
    @(posedge clk);
    step(0, 1, 0, 0, 0, 0, "rst1", 5'b00000, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, "rst3", 5'b00000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, "reset_state", 5'b11111, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, "reset_state3", 5'b11111, 1, 1, 0, 0, 0);

    // Write then read back 1028
    wr_access("wr1028", 32'd1028, 32'hDEADBEEF, 0, 32'h0);
    idle(0, "gap0");
    rd_access("rd1028", 32'd1028, 32'hDEADBEEF);
    idle(0, "gap1");

    // Write wins over read; rdata keeps the previous load value
    wr_access("rw1032", 32'd1032, 32'h12345678, 1, 32'hDEADBEEF);
    idle(0, "gap2");

    // Back-to-back: read held through DONE, write starts in the next IDLE cycle
    rd_access("b2b_rd", 32'd1032, 32'h12345678);
    wr_access("b2b_wr", 32'd1036, 32'hCAFEF00D, 0, 32'h12345678);
    idle(0, "gap3");
    rd_access("rd1036", 32'd1036, 32'hCAFEF00D);

    // Reset in the first beat of a write, request held, then dropped mid-access
    step(0, 0, 0, 1, 32'd1040, 32'h55AA66BB, "rstw_n0", 5'b00011, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 32'd1040, 32'h55AA66BB, "rstw_b0", 5'b01111, 0, 0, 8, 16'h66BB, 0);
    step(0, 0, 0, 1, 32'd1040, 32'h55AA66BB, "rstw_idle", 5'b10111, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 32'd1040, 32'h0, "rstw_b0b", 5'b01111, 1, 0, 8, 16'h66BB, 0);
    step(0, 0, 0, 0, 32'd1040, 32'h0, "rstw_b1b", 5'b01111, 1, 0, 9, 16'h55AA, 0);
    step(0, 0, 0, 0, 32'd1040, 32'h0, "rstw_dn", 5'b00011, 1, 1, 0, 0, 0);
    rd_access("rd1040", 32'd1040, 32'h55AA66BB);

    for (int i = 0; i < 10; i++) idle(0, "idle");

    // WAIT_CYCLES=3: write then read word 0
    step(1, 0, 0, 1, 32'd1024, 32'hA5A55A5A, "w3_n0", 5'b00011, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(1, 0, 0, 1, 32'd1024, 32'hA5A55A5A, "w3_beat", 5'b01111, 0, 0,
           (i < 3) ? 18'd0 : 18'd1, (i < 3) ? 16'h5A5A : 16'hA5A5, 0);
    step(1, 0, 0, 1, 32'd1024, 32'hA5A55A5A, "w3_dn", 5'b00011, 1, 1, 0, 0, 0);
    idle(1, "gap3w");
    step(1, 0, 1, 0, 32'd1024, 0, "r3_n0", 5'b00011, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(1, 0, 1, 0, 32'd1024, 0, "r3_beat", 5'b00111, 0, 1,
           (i < 3) ? 18'd0 : 18'd1, 0, 0);
    step(1, 0, 1, 0, 32'd1024, 0, "r3_dn", 5'b10011, 1, 1, 0, 0, 32'hA5A55A5A);
    idle(1, "end3");

    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
